pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
// - Owns the program counter register; consumer of the PC adder result (PC -> adder -> pcPlus4 -> back in here).
// - Issues instruction-memory fetches over a req/ack handshake and presents each fetched instruction to decode over a valid/ready handshake.
// - Applies branch redirects and stalls.
// - Sits between the PC adder / branch mux and the instruction memory / decode stage.
// PARAMETERS
// - RESET_PC   32'h0000_0000   PC value loaded on reset
// - ADDR_W     32              address / PC width
// - INSTR_W    32              instruction word width
// PORTS
// - clock         in   1        single clock, rising edge
// - reset         in   1        synchronous, active-high
// - PC            out  ADDR_W   current PC, to PC adder
// - pcPlus4       in   ADDR_W   PC adder result (PC+4)
// - branchTaken   in   1        redirect request this cycle
// - branchTarget  in   ADDR_W   redirect address
// - stall         in   1        freeze fetch progress
// - imemReq       out  1        fetch request to instruction memory
// - imemAddr      out  ADDR_W   fetch address; stable while imemReq=1 until imemAck
// - imemAck       in   1        single-cycle completion; imemData valid same cycle
// - imemData      in   INSTR_W  fetched word
// - instrValid    out  1        instr/instrPC valid to decode
// - instr         out  INSTR_W  buffered instruction
// - instrPC       out  ADDR_W   PC of buffered instruction
// - instrReady    in   1        decode accepts when instrValid=1
// - misaligned    out  1        one-cycle pulse: branchTarget[1:0]!=0
// BEHAVIOUR
// - Reset: PC=RESET_PC; imemAddr=RESET_PC; imemReq=0; instrValid=0; instr=0; instrPC=0; misaligned=0; state=IDLE.
// - States: IDLE, REQ, HOLD, SQUASH. Priority: reset > branchTaken > stall > normal.
// - Redirect address = {branchTarget[ADDR_W-1:2],2'b00}; misaligned pulses on the next cycle when bits[1:0]!=0.
// - IDLE: !stall -> REQ (imemReq=1, imemAddr=PC); stall -> stay; branchTaken -> PC=redirect, stay IDLE.
// - REQ: imemReq=1.
//   - imemAck & !branchTaken -> instr=imemData, instrPC=imemAddr, instrValid=1, imemReq=0, HOLD.
//   - branchTaken & imemAck -> data dropped, PC=imemAddr=redirect, stay REQ (new request next cycle).
//   - branchTaken & !imemAck -> PC=redirect, SQUASH; imemReq/imemAddr keep the old request.
//   - stall does not cancel an outstanding request.
// - SQUASH: hold old request until imemAck; drop data; then REQ with imemAddr=PC. Further branchTaken here only updates PC (last wins).
// - HOLD:
//   - branchTaken -> instrValid=0, PC=redirect, REQ.
//   - stall -> all state frozen.
//   - instrValid & instrReady & !stall -> PC=pcPlus4, instrValid=0, REQ with imemAddr=pcPlus4.
// - Throughput: ack in first REQ cycle + instrReady=1 -> one instruction per 2 cycles.
// - Latency: ack cycle -> instrValid the next cycle.
// - Arithmetic: PC wraps modulo 2^ADDR_W (0xFFFF_FFFC + 4 = 0); no internal add, pcPlus4 used as given.
// - Reset mid-operation: outstanding request abandoned; imemReq=0 the next cycle; memory must tolerate it.
// CONFIGURATION
// - PC_TRACE_EN defined:
//   - extra port fetchCount out 32: count of handoffs (instrValid & instrReady & !stall & !branchTaken), wrapping.
//   - cleared by reset.
// - PC_TRACE_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
// - reset=1 2 cycles, RESET_PC=0 -> PC=0, imemReq=0, instrValid=0; 1 cycle after release imemReq=1, imemAddr=0.
// - ack in each REQ cycle, data=PC^0xA5A5A5A5, instrReady=1 -> instrPC 0,4,8,C; one instruction per 2 cycles.
// - HOLD with instr@0x8, branchTaken=1, target=0x100 -> instrValid=0 next cycle; imemAddr=0x100, imemReq=1.
// - REQ with ack=0, branchTaken target=0x200; ack 2 cycles later with 0xDEADBEEF -> never on instr; next imemAddr=0x200.
// - HOLD, instrReady=1, stall=1 for 3 cycles -> PC/instr/instrPC stable; stall=0 -> advance to pcPlus4.
// - branchTarget=0x103 -> misaligned=1 for exactly 1 cycle; next imemAddr=0x100.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter owner and instruction fetch front end: req/ack fetch to imem, valid/ready handoff to decode.
// Optional handoff counter port fetchCount is present when PC_TRACE_EN is defined.
module pc_fetch_unit #(
  parameter int               ADDR_W   = 32,
  parameter int               INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  PC,
  input  logic [ADDR_W-1:0]  pcPlus4,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchTarget,
  input  logic               stall,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemAck,
  input  logic [INSTR_W-1:0] imemData,
  output logic               instrValid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instrPC,
  input  logic               instrReady,
  output logic               misaligned
`ifdef PC_TRACE_EN
  ,
  output logic [31:0]        fetchCount
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, SQUASH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] redirect;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              load_instr;
  logic              handoff;

  assign redirect = {branchTarget[ADDR_W-1:2], 2'b00};
  assign handoff  = instrValid & instrReady & ~stall & ~branchTaken;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; branchTaken outranks stall everywhere
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!branchTaken && !stall) state_nxt = REQ;
      REQ: begin
        if (branchTaken)  state_nxt = imemAck ? REQ : SQUASH;
        else if (imemAck) state_nxt = HOLD;
      end
      SQUASH: if (imemAck) state_nxt = REQ;
      HOLD: begin
        if (branchTaken)                state_nxt = REQ;
        else if (!stall && instrReady) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs and datapath load controls
  always_comb begin
    imemReq    = (state == REQ) || (state == SQUASH);
    instrValid = (state == HOLD);
    pc_nxt     = PC;
    addr_nxt   = imemAddr;
    load_instr = 1'b0;
    case (state)
      IDLE: begin
        if (branchTaken) pc_nxt   = redirect;
        else if (!stall) addr_nxt = PC;
      end
      REQ: begin
        if (branchTaken) begin
          pc_nxt = redirect;
          if (imemAck) addr_nxt = redirect;
        end else if (imemAck) begin
          load_instr = 1'b1;
        end
      end
      SQUASH: begin
        // A redirect arriving with the ack must win, so the new fetch uses the updated PC
        if (branchTaken) pc_nxt = redirect;
        if (imemAck) addr_nxt = branchTaken ? redirect : PC;
      end
      HOLD: begin
        if (branchTaken) begin
          pc_nxt   = redirect;
          addr_nxt = redirect;
        end else if (!stall && instrReady) begin
          pc_nxt   = pcPlus4;
          addr_nxt = pcPlus4;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      PC         <= RESET_PC;
      imemAddr   <= RESET_PC;
      instr      <= '0;
      instrPC    <= '0;
      misaligned <= 1'b0;
    end else begin
      PC         <= pc_nxt;
      imemAddr   <= addr_nxt;
      misaligned <= branchTaken && (branchTarget[1:0] != 2'b00);
      if (load_instr) begin
        instr   <= imemData;
        instrPC <= imemAddr;
      end
    end
  end

`ifdef PC_TRACE_EN
  always_ff @(posedge clock) begin
    if (reset)        fetchCount <= '0;
    else if (handoff) fetchCount <= fetchCount + 32'd1;
  end
`else
  logic unused_handoff;
  assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the fetch unit.
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, branchTaken, stall, imemAck, instrReady;
  logic [31:0] pcPlus4, branchTarget, imemData;
  logic [31:0] PC, imemAddr, instr, instrPC;
  logic        imemReq, instrValid, misaligned;
`ifdef PC_TRACE_EN
  logic [31:0] fetchCount;
`endif

  always #5 clock = ~clock;

  // External PC adder
  assign pcPlus4 = PC + 32'd4;

  pc_fetch_unit dut (
    .clock(clock), .reset(reset), .PC(PC), .pcPlus4(pcPlus4),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .stall(stall),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instrValid(instrValid), .instr(instr), .instrPC(instrPC),
    .instrReady(instrReady), .misaligned(misaligned)
`ifdef PC_TRACE_EN
    , .fetchCount(fetchCount)
`endif
  );

  int errs   = 0;
  int checks = 0;

  // Model: an outstanding request (possibly doomed), a one-entry buffer to decode, and the PC
  logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_cnt;
  logic        m_req, m_doomed, m_valid, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] red;
    red = {branchTarget[31:2], 2'b00};
    if (reset) begin
      m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
      m_req = 1'b0; m_doomed = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
      return;
    end
    m_mis = branchTaken && (branchTarget % 4 != 0);
    if (m_valid) begin
      if (branchTaken) begin
        m_valid = 1'b0; m_pc = red; m_req = 1'b1; m_addr = red;
      end else if (!stall && instrReady) begin
        m_cnt   = m_cnt + 1;
        m_valid = 1'b0; m_pc = m_pc + 4; m_req = 1'b1; m_addr = m_pc;
      end
    end else if (m_req) begin
      if (imemAck) begin
        if (m_doomed || branchTaken) begin
          if (branchTaken) m_pc = red;
          m_addr = m_pc; m_doomed = 1'b0;
        end else begin
          m_valid = 1'b1; m_instr = imemData; m_ipc = m_addr; m_req = 1'b0;
        end
      end else if (branchTaken) begin
        m_pc = red; m_doomed = 1'b1;
      end
    end else begin
      if (branchTaken)  m_pc = red;
      else if (!stall) begin
        m_req = 1'b1; m_addr = m_pc;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic br, input logic [31:0] tgt, input logic st,
                     input logic ack, input logic [31:0] dat, input logic rdy);
    reset = rst; branchTaken = br; branchTarget = tgt; stall = st;
    imemAck = ack; imemData = dat; instrReady = rdy;
    model_step();
    @(posedge clock);
    #1;
    chk("pc", PC, m_pc);
    chk("imem_req", {31'b0, imemReq}, {31'b0, m_req});
    chk("imem_addr", imemAddr, m_addr);
    chk("instr_valid", {31'b0, instrValid}, {31'b0, m_valid});
    chk("instr", instr, m_instr);
    chk("instr_pc", instrPC, m_ipc);
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
`ifdef PC_TRACE_EN
    chk("fetch_count", fetchCount, m_cnt);
`endif
  endtask

  task automatic idle_cyc(input logic ack, input logic rdy, input logic st);
    cyc(1'b0, 1'b0, 32'h0, st, ack, m_addr ^ 32'hA5A5_A5A5, rdy);
  endtask

  initial begin
    reset = 1'b1; branchTaken = 1'b0; branchTarget = '0; stall = 1'b0;
    imemAck = 1'b0; imemData = '0; instrReady = 1'b0;
    m_cnt = 32'h0;

    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_req", {31'b0, imemReq}, 32'h0);
    chk("rst_valid", {31'b0, instrValid}, 32'h0);

    idle_cyc(1'b0, 1'b1, 1'b0);
    chk("first_req", {31'b0, imemReq}, 32'h1);
    chk("first_addr", imemAddr, 32'h0);

    // Back-to-back fetch: one instruction every two cycles
    for (int k = 0; k < 4; k++) begin
      idle_cyc(1'b1, 1'b1, 1'b0);
      chk("seq_valid", {31'b0, instrValid}, 32'h1);
      chk("seq_ipc", instrPC, 32'(k * 4));
      chk("seq_instr", instr, 32'(k * 4) ^ 32'hA5A5_A5A5);
      idle_cyc(1'b0, 1'b1, 1'b0);
      chk("seq_gap", {31'b0, instrValid}, 32'h0);
      chk("seq_next_addr", imemAddr, 32'(k * 4 + 4));
    end

    // Redirect out of HOLD
    idle_cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("hold_br_valid", {31'b0, instrValid}, 32'h0);
    chk("hold_br_addr", imemAddr, 32'h100);
    chk("hold_br_req", {31'b0, imemReq}, 32'h1);

    // Redirect with request outstanding: late data must be dropped
    cyc(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("sq_old_addr", imemAddr, 32'h100);
    chk("sq_pc", PC, 32'h200);
    idle_cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("sq_dropped", {31'b0, instrValid}, 32'h0);
    chk("sq_new_addr", imemAddr, 32'h200);
    chk("sq_new_req", {31'b0, imemReq}, 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    chk("sq_instr", instr, 32'h1234_5678);
    chk("sq_ipc", instrPC, 32'h200);

    // Stall in HOLD freezes everything
    for (int k = 0; k < 3; k++) begin
      idle_cyc(1'b0, 1'b1, 1'b1);
      chk("stall_pc", PC, 32'h200);
      chk("stall_ipc", instrPC, 32'h200);
      chk("stall_valid", {31'b0, instrValid}, 32'h1);
    end
    idle_cyc(1'b0, 1'b1, 1'b0);
    chk("unstall_pc", PC, 32'h204);
    chk("unstall_addr", imemAddr, 32'h204);

    // Misaligned target, redirect coincident with ack
    cyc(1'b0, 1'b1, 32'h103, 1'b0, 1'b1, 32'h0, 1'b1);
    chk("mis_pulse", {31'b0, misaligned}, 32'h1);
    chk("mis_addr", imemAddr, 32'h100);
    idle_cyc(1'b0, 1'b1, 1'b0);
    chk("mis_clear", {31'b0, misaligned}, 32'h0);

    // PC wrap at the top of the address space
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0, 1'b1);
    idle_cyc(1'b1, 1'b0, 1'b0);
    chk("wrap_ipc", instrPC, 32'hFFFF_FFFC);
    idle_cyc(1'b0, 1'b1, 1'b0);
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_addr", imemAddr, 32'h0);

    // Randomized traffic, including occasional mid-operation reset
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_br, r_st, r_ack, r_rdy;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 199) == 0);
      r_br  = ($urandom_range(0, 99) < 12);
      r_st  = ($urandom_range(0, 99) < 25);
      r_ack = m_req && ($urandom_range(0, 2) != 0);
      r_rdy = ($urandom_range(0, 99) < 70);
      r_tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : ($urandom & 32'h0000_FFFF);
      cyc(r_rst, r_br, r_tgt, r_st, r_ack, $urandom, r_rdy);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
